// File: rtl/lc3b_ctrl_sequencer.sv
// lc3b_ctrl_sequencer: ID-stage decode, LDI/STI two-phase sequencer and control-word stage chain.
// Optional watchdog on the indirect pointer fetch is enabled by defining CTRL_SEQ_TIMEOUT_EN.
package lc3b_ctrl_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add  = 4'b0001, op_ldb  = 4'b0010, op_stb  = 4'b0011,
    op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldr  = 4'b0110, op_str  = 4'b0111,
    op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi  = 4'b1010, op_sti  = 4'b1011,
    op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea  = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  // alumux: 0 sr2, 1 imm4, 2 adj6, 3 imm5, 4 offset6
  // pcmux: 0 pc+2, 1 adder, 2 register, 3 memory; regfilemux: 0 alu, 1 mdr, 2 pc, 3 adder, 4 byte
  typedef struct packed {
    lc3b_aluop  aluop;
    logic [2:0] alumux_sel;
    logic [1:0] pcmux_sel;
    logic [2:0] regfilemux_sel;
    logic [1:0] datamux_sel;
    logic       storemux_sel;
    logic       writemux_sel;
    logic       destmux_sel;
    logic       adder_sel;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       branch_en;
  } lc3b_control_word;

  function automatic lc3b_control_word ctrl_blank();
    lc3b_control_word w;
    w       = '0;
    w.aluop = alu_add;
    return w;
  endfunction

  function automatic lc3b_control_word ctrl_nop();
    lc3b_control_word w;
    w                = ctrl_blank();
    w.pcmux_sel      = 2'd3;
    w.regfilemux_sel = 3'd4;
    w.datamux_sel    = 2'd2;
    return w;
  endfunction

endpackage

module lc3b_ctrl_sequencer
  import lc3b_ctrl_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  lc3b_opcode       opcode,
  input  logic             bit11,
  input  logic             bit5,
  input  logic             bit4,
  input  logic             stall_in,
  input  logic             dmem_resp,
  output lc3b_control_word ctrl_id,
  output lc3b_control_word ctrl_stage [STAGES],
  output logic             load_pipe,
  output logic             ind_phase,
  output logic             seq_err
);

  if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
    $error("lc3b_ctrl_sequencer: STAGES must be 1..6");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("lc3b_ctrl_sequencer: TIMEOUT must be 2..255");
  end

  typedef enum logic [1:0] {s_idle, s_wait1, s_issue2} state_t;

  state_t state, next_state;
  logic   is_ind;
  logic   wd_expire;
  logic   wd_drop;

  assign is_ind = valid_in && (opcode == op_ldi || opcode == op_sti);

  function automatic lc3b_control_word decode(input lc3b_opcode op,
                                              input logic b11, input logic b5, input logic b4);
    lc3b_control_word w;
    w = ctrl_blank();
    case (op)
      op_br:  w.branch_en = 1'b1;
      op_add, op_and: begin
        w.aluop        = (op == op_add) ? alu_add : alu_and;
        w.alumux_sel   = b5 ? 3'd3 : 3'd0;
        w.load_regfile = 1'b1;
        w.load_cc      = 1'b1;
      end
      op_not: begin
        w.aluop = alu_not; w.load_regfile = 1'b1; w.load_cc = 1'b1;
      end
      op_ldr: begin
        w.alumux_sel = 3'd2; w.mem_read = 1'b1; w.regfilemux_sel = 3'd1;
        w.load_regfile = 1'b1; w.load_cc = 1'b1;
      end
      op_str: begin
        w.alumux_sel = 3'd2; w.mem_write = 1'b1; w.storemux_sel = 1'b1;
      end
      op_jmp: w.pcmux_sel = 2'd2;
      op_jsr: begin
        w.destmux_sel = 1'b1; w.regfilemux_sel = 3'd2; w.load_regfile = 1'b1;
        w.pcmux_sel   = b11 ? 2'd1 : 2'd2;
        w.adder_sel   = b11;
      end
      op_ldb: begin
        w.alumux_sel = 3'd4; w.mem_read = 1'b1; w.regfilemux_sel = 3'd4;
        w.load_regfile = 1'b1; w.load_cc = 1'b1;
      end
      op_stb: begin
        w.alumux_sel = 3'd4; w.mem_write = 1'b1; w.storemux_sel = 1'b1; w.writemux_sel = 1'b1;
      end
      op_lea: begin
        w.regfilemux_sel = 3'd3; w.load_regfile = 1'b1; w.load_cc = 1'b1;
      end
      op_shf: begin
        w.aluop        = b4 ? (b5 ? alu_sra : alu_srl) : alu_sll;
        w.alumux_sel   = 3'd1;
        w.load_regfile = 1'b1;
        w.load_cc      = 1'b1;
      end
      op_trap: begin
        w.destmux_sel = 1'b1; w.regfilemux_sel = 3'd2; w.load_regfile = 1'b1;
        w.mem_read    = 1'b1; w.pcmux_sel = 2'd3;
      end
      default: w = ctrl_nop();
    endcase
    return w;
  endfunction

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    ctrl_id    = ctrl_nop();
    load_pipe  = 1'b1;
    ind_phase  = 1'b0;
    seq_err    = 1'b0;
    case (state)
      s_idle: begin
        if (wd_drop) begin
          // the aborted indirect op still sits in IF/ID; let it fall out as a bubble
        end else if (is_ind) begin
          ctrl_id            = ctrl_blank();
          ctrl_id.alumux_sel = 3'd2;
          ctrl_id.mem_read   = 1'b1;
          load_pipe          = 1'b0;
          next_state         = s_wait1;
        end else if (valid_in) begin
          ctrl_id = decode(opcode, bit11, bit5, bit4);
        end
      end
      s_wait1: begin
        load_pipe = 1'b0;
        if (dmem_resp) begin
          next_state = s_issue2;
        end else if (wd_expire) begin
          next_state = s_idle;
          seq_err    = 1'b1;
        end
      end
      s_issue2: begin
        ind_phase           = 1'b1;
        ctrl_id             = ctrl_blank();
        ctrl_id.datamux_sel = 2'd1;
        if (opcode == op_ldi) begin
          ctrl_id.mem_read       = 1'b1;
          ctrl_id.regfilemux_sel = 3'd1;
          ctrl_id.load_regfile   = 1'b1;
          ctrl_id.load_cc        = 1'b1;
        end else begin
          ctrl_id.storemux_sel = 1'b1;
          ctrl_id.mem_write    = 1'b1;
        end
        next_state = s_idle;
      end
      default: next_state = s_idle;
    endcase
    if (stall_in) begin
      next_state = state;
      load_pipe  = 1'b0;
      seq_err    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= s_idle;
    else       state <= next_state;
  end

  // NOTE: the stage chain is a handful of flops, not a RAM, so it is reset to a known NOP bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ctrl_stage[i] <= ctrl_nop();
    end else if (!stall_in) begin
      ctrl_stage[0] <= ctrl_id;
      for (int i = 1; i < STAGES; i++) ctrl_stage[i] <= ctrl_stage[i-1];
    end
  end

`ifdef CTRL_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;

  assign wd_expire = (state == s_wait1) && (wd_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= 8'd0;
      wd_drop <= 1'b0;
    end else if (!stall_in) begin
      wd_cnt  <= (state == s_wait1 && next_state == s_wait1) ? wd_cnt + 8'd1 : 8'd0;
      wd_drop <= seq_err;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_drop   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_ctrl_sequencer.sv
// Randomized bench for lc3b_ctrl_sequencer against an instruction-level reference model.
// Define CTRL_SEQ_TIMEOUT_EN for both bench and RTL to exercise the watchdog (TIMEOUT=8 here).
module tb_lc3b_ctrl_sequencer;
  import lc3b_ctrl_pkg::*;

  localparam int STAGES  = 3;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  lc3b_opcode       opcode = op_br;
  logic             bit11 = 1'b0, bit5 = 1'b0, bit4 = 1'b0;
  logic             stall_in = 1'b0;
  logic             dmem_resp = 1'b0;
  lc3b_control_word ctrl_id;
  lc3b_control_word ctrl_stage [STAGES];
  logic             load_pipe, ind_phase, seq_err;

  lc3b_ctrl_sequencer #(.STAGES(STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .bit11(bit11), .bit5(bit5), .bit4(bit4), .stall_in(stall_in), .dmem_resp(dmem_resp),
    .ctrl_id(ctrl_id), .ctrl_stage(ctrl_stage), .load_pipe(load_pipe),
    .ind_phase(ind_phase), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference words, written field by field from the instruction semantics.
  function automatic lc3b_control_word w_zero();
    lc3b_control_word w;
    w = '0;
    return w;
  endfunction

  function automatic lc3b_control_word w_nop();
    lc3b_control_word w = w_zero();
    w.pcmux_sel = 2'd3; w.regfilemux_sel = 3'd4; w.datamux_sel = 2'd2;
    return w;
  endfunction

  function automatic lc3b_control_word w_writes_reg(input lc3b_control_word w, input bit cc);
    w.load_regfile = 1'b1;
    w.load_cc      = cc;
    return w;
  endfunction

  function automatic lc3b_control_word w_direct(input lc3b_opcode op, input bit b11,
                                                input bit b5, input bit b4);
    lc3b_control_word w = w_zero();
    if (op == op_add || op == op_and || op == op_not) begin
      w.aluop      = (op == op_add) ? alu_add : (op == op_and) ? alu_and : alu_not;
      w.alumux_sel = (op != op_not && b5) ? 3'd3 : 3'd0;
      return w_writes_reg(w, 1);
    end
    if (op == op_shf) begin
      w.aluop      = !b4 ? alu_sll : (b5 ? alu_sra : alu_srl);
      w.alumux_sel = 3'd1;
      return w_writes_reg(w, 1);
    end
    if (op == op_ldr || op == op_ldb) begin
      w.alumux_sel     = (op == op_ldr) ? 3'd2 : 3'd4;
      w.regfilemux_sel = (op == op_ldr) ? 3'd1 : 3'd4;
      w.mem_read       = 1'b1;
      return w_writes_reg(w, 1);
    end
    if (op == op_str || op == op_stb) begin
      w.alumux_sel   = (op == op_str) ? 3'd2 : 3'd4;
      w.mem_write    = 1'b1;
      w.storemux_sel = 1'b1;
      w.writemux_sel = (op == op_stb);
      return w;
    end
    if (op == op_jsr || op == op_trap) begin
      w.destmux_sel    = 1'b1;
      w.regfilemux_sel = 3'd2;
      w.pcmux_sel      = (op == op_trap) ? 2'd3 : (b11 ? 2'd1 : 2'd2);
      w.adder_sel      = (op == op_jsr) && b11;
      w.mem_read       = (op == op_trap);
      return w_writes_reg(w, 0);
    end
    if (op == op_lea) begin
      w.regfilemux_sel = 3'd3;
      return w_writes_reg(w, 1);
    end
    if (op == op_br)  begin w.branch_en = 1'b1; return w; end
    if (op == op_jmp) begin w.pcmux_sel = 2'd2; return w; end
    return w_nop();
  endfunction

  function automatic lc3b_control_word w_ptr_fetch();
    lc3b_control_word w = w_zero();
    w.alumux_sel = 3'd2; w.mem_read = 1'b1;
    return w;
  endfunction

  function automatic lc3b_control_word w_final(input bit ldi);
    lc3b_control_word w = w_zero();
    w.datamux_sel = 2'd1;
    if (ldi) begin
      w.mem_read = 1'b1; w.regfilemux_sel = 3'd1;
      w = w_writes_reg(w, 1);
    end else begin
      w.storemux_sel = 1'b1; w.mem_write = 1'b1;
    end
    return w;
  endfunction

  // Model of what the ID stage holds: 0 free, 1 awaiting pointer, 2 final access, 3 dropped op.
  int               mode = 0;
  int               wait_cycles = 0;
  bit               is_ldi = 0;
  bit               starve = 0;
  lc3b_control_word pipe_q [$];
  lc3b_control_word e_id;
  bit               e_lp = 1, e_ip = 0, e_se = 0, e_ind = 0, e_expire = 0;

  task automatic model_reset();
    mode = 0; wait_cycles = 0; e_lp = 1;
    pipe_q.delete();
    for (int i = 0; i < STAGES; i++) pipe_q.push_back(w_nop());
  endtask

  task automatic compare_outputs();
    e_ind    = valid_in && (opcode == op_ldi || opcode == op_sti);
    e_expire = 0; e_se = 0; e_ip = 0; e_lp = 1;
    case (mode)
      0: begin
        e_id = e_ind ? w_ptr_fetch() : (valid_in ? w_direct(opcode, bit11, bit5, bit4) : w_nop());
        e_lp = !e_ind;
      end
      1: begin
        e_id = w_nop();
        e_lp = 0;
`ifdef CTRL_SEQ_TIMEOUT_EN
        e_expire = !dmem_resp && (wait_cycles == TIMEOUT - 1);
`endif
        e_se = e_expire && !stall_in;
      end
      2: begin e_id = w_final(is_ldi); e_ip = 1; end
      default: e_id = w_nop();
    endcase
    if (stall_in) e_lp = 0;
    check("ctrl_id",   32'(ctrl_id),   32'(e_id));
    check("load_pipe", 32'(load_pipe), 32'(e_lp));
    check("ind_phase", 32'(ind_phase), 32'(e_ip));
    check("seq_err",   32'(seq_err),   32'(e_se));
    for (int i = 0; i < STAGES; i++)
      check($sformatf("ctrl_stage[%0d]", i), 32'(ctrl_stage[i]), 32'(pipe_q[i]));
  endtask

  task automatic advance();
    if (stall_in) return;
    pipe_q.push_front(e_id);
    void'(pipe_q.pop_back());
    case (mode)
      0: if (e_ind) begin
        mode = 1; wait_cycles = 0; is_ldi = (opcode == op_ldi); starve = ($urandom % 4) == 0;
      end
      1: if (dmem_resp) mode = 2;
         else if (e_expire) mode = 3;
         else wait_cycles++;
      default: mode = 0;
    endcase
  endtask

  task automatic drive();
    if (e_lp) begin
      valid_in = ($urandom % 8) != 0;
      if (($urandom % 4) == 0) opcode = ($urandom % 2) ? op_ldi : op_sti;
      else                     opcode = lc3b_opcode'(4'($urandom_range(0, 15)));
      bit11 = 1'($urandom); bit5 = 1'($urandom); bit4 = 1'($urandom);
    end
    stall_in  = ($urandom % 6) == 0;
    dmem_resp = (mode == 1 && starve && wait_cycles < 12) ? 1'b0 : (($urandom % 3) == 0);
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    advance();
    #1 drive();
  endtask

  bit reset_done = 0;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
    drive();

    for (int n = 0; n < 800; n++) begin
      step();
      if (!reset_done && n > 200 && mode == 1) begin
        reset = 1'b1; valid_in = 1'b0; stall_in = 1'b0; dmem_resp = 1'b0;
        #1;
        for (int i = 0; i < STAGES; i++)
          check($sformatf("rst_ctrl_stage[%0d]", i), 32'(ctrl_stage[i]), 32'(w_nop()));
        check("rst_load_pipe", 32'(load_pipe), 32'd1);
        check("rst_ind_phase", 32'(ind_phase), 32'd0);
        check("rst_seq_err",   32'(seq_err),   32'd0);
        model_reset();
        #2 reset = 1'b0;
        reset_done = 1;
      end
    end
    if (!reset_done) check("reset_mid_wait_reached", 32'(reset_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
